// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] inst_t;
    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros and is the canonical bubble.
    localparam inst_t NOP_INST = 32'h0000_0000;

    // Redirect targets are word-aligned by dropping the byte offset.
    function automatic addr_t align_word(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, hazard controls, redirect and IF/ID outputs.
// Latency: n/a (signal bundle only).
// Backpressure: stall_i holds the stage; there is no ready/valid toward memory.
interface fetch_stage_if #(
    parameter int unsigned CNT_W = 32
);
    import mips_pkg::*;

    addr_t             imem_addr_o;
    inst_t             imem_inst_i;
    logic              stall_i;
    logic              flush_i;
    logic              redir_valid_i;
    addr_t             redir_pc_i;
    inst_t             ifid_inst_o;
    addr_t             ifid_pc4_o;
    logic              ifid_valid_o;
    logic [CNT_W-1:0]  fetch_cnt_o;

    // Fetch stage side.
    modport master (
        output imem_addr_o,
        input  imem_inst_i,
        input  stall_i,
        input  flush_i,
        input  redir_valid_i,
        input  redir_pc_i,
        output ifid_inst_o,
        output ifid_pc4_o,
        output ifid_valid_o,
        output fetch_cnt_o
    );

    // Memory / later-stage side.
    modport slave (
        input  imem_addr_o,
        output imem_inst_i,
        output stall_i,
        output flush_i,
        output redir_valid_i,
        output redir_pc_i,
        input  ifid_inst_o,
        input  ifid_pc4_o,
        input  ifid_valid_o,
        input  fetch_cnt_o
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit with bubble/hold/load.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: hold_i freezes all fields; bubble_i overrides hold.
module ifid_reg
    import mips_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  bubble_i,
    input  logic  hold_i,
    input  inst_t inst_i,
    input  addr_t pc4_i,
    output inst_t inst_o,
    output addr_t pc4_o,
    output logic  valid_o
);

    inst_t inst_q, inst_d;
    addr_t pc4_q, pc4_d;
    logic  valid_q, valid_d;

    // Bubble beats hold beats load.
    always_comb begin
        inst_d  = inst_i;
        pc4_d   = pc4_i;
        valid_d = 1'b1;
        if (bubble_i) begin
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (hold_i) begin
            inst_d  = inst_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    // Register with asynchronous clear to an empty bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID capture and fetch counter.
// Latency: 1 cycle from imem_addr_o to IF/ID outputs; 1 instruction per cycle.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; flush bubbles IF/ID.
module fetch_stage
    import mips_pkg::*;
#(
    parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    fetch_stage_if.master bus
);

    addr_t            pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    addr_t            pc_plus4;
    logic             bubble;
    logic             hold;
    logic             load_valid;

    // Sequential address wraps naturally at 2^32.
    assign pc_plus4   = pc_q + 32'd4;
    assign bubble     = bus.redir_valid_i | bus.flush_i;
    assign hold       = bus.stall_i;
    assign load_valid = !bubble && !hold;

    // Next PC: redirect > stall > sequential; flush does not touch the PC.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.redir_valid_i) begin
            pc_d = align_word(bus.redir_pc_i);
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end
    end

    // Count only edges that place a real instruction into IF/ID.
    always_comb begin
        cnt_d = cnt_q;
        if (load_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // PC and counter state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .bubble_i (bubble),
        .hold_i   (hold),
        .inst_i   (bus.imem_inst_i),
        .pc4_i    (pc_plus4),
        .inst_o   (bus.ifid_inst_o),
        .pc4_o    (bus.ifid_pc4_o),
        .valid_o  (bus.ifid_valid_o)
    );

    assign bus.imem_addr_o = pc_q;
    assign bus.fetch_cnt_o = cnt_q;

endmodule
